// File: rtl/l1_arb_pkg.sv
// l1_arb_pkg: shared types and helpers for the L1 read-only burst arbiter.
//   l1_arb_state_t   : arbiter FSM states (IDLE, REQ, DATA)
//   L1_ARB_RLEN_W    : default burst length field width (beats = rlen+1)
//   L1_ARB_MAX_REQ   : largest supported requester count
//   priority_encoder : index of the lowest set bit of a request vector
package l1_arb_pkg;

    localparam int L1_ARB_RLEN_W  = 5;
    localparam int L1_ARB_MAX_REQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } l1_arb_state_t;

    // Lowest index wins; returns 0 for an empty vector (callers gate with |v).
    function automatic logic [1:0] priority_encoder(input logic [L1_ARB_MAX_REQ-1:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = L1_ARB_MAX_REQ - 1; i >= 0; i--) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/l1_arb_select.sv
// l1_arb_select: combinational winner chooser for l1_ro_arbiter.
// Build option: L1_RO_ARBITER_ROUND_ROBIN_EN selects round-robin search
// starting at ptr+1 (mod NUM_REQ); otherwise fixed priority, lowest index
// wins and ptr is ignored.
// Ports:
//   req  in  NUM_REQ  candidate requests
//   ptr  in  ID_W     last granted id (round-robin only)
//   gnt  out NUM_REQ  one-hot winner (zero when no request)
//   id   out ID_W     encoded winner
//   any  out 1        at least one request present
import l1_arb_pkg::*;

module l1_arb_select #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    id,
    output logic               any
);

    logic [L1_ARB_MAX_REQ-1:0] vec;
    logic [1:0]                off;

`ifdef L1_RO_ARBITER_ROUND_ROBIN_EN
    // One extra bit so ptr+1+k never overflows before the modulo wrap.
    logic [ID_W:0] pos;

    always_comb begin
        vec = '0;
        pos = '0;
        // Rotate requests so vec[0] is the requester right after ptr.
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, ptr} + (ID_W+1)'(k + 1);
            if (pos >= (ID_W+1)'(NUM_REQ)) pos = pos - (ID_W+1)'(NUM_REQ);
            vec[k] = req[pos[ID_W-1:0]];
        end
        off = priority_encoder(vec);
        pos = {1'b0, ptr} + (ID_W+1)'(off) + (ID_W+1)'(1);
        if (pos >= (ID_W+1)'(NUM_REQ)) pos = pos - (ID_W+1)'(NUM_REQ);
        id = pos[ID_W-1:0];
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        vec = '0;
        vec[NUM_REQ-1:0] = req;
        off = priority_encoder(vec);
        id  = ID_W'(off);
    end
`endif

    assign any = |req;

    always_comb begin
        gnt = '0;
        if (any) gnt[id] = 1'b1;
    end

endmodule

// File: rtl/l1_ro_arbiter.sv
// l1_ro_arbiter: shares one read-only burst memory port between NUM_REQ
// line-fill requesters. One burst outstanding; the winner's request is
// latched, forwarded, acked and its rlen+1 beats are steered back to it.
// Build option: L1_RO_ARBITER_ROUND_ROBIN_EN enables round-robin arbitration
// (pointer = last granted id); default is fixed priority, lowest index wins.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_request[N]    per-requester request, held until its ack
//   req_addr[N*A]     per-requester word address (flattened, req i at i*ADDR_W)
//   req_rlen[N*R]     per-requester burst length minus 1 (flattened)
//   req_ack[N]        one-hot acceptance pulse to the winner
//   req_rvalid[N]     one-hot beat valid to the granted requester
//   req_rdata[32]     beat data, broadcast
//   mem_request/addr/rlen  request to memory (held until mem_ack)
//   mem_ack, mem_rvalid, mem_rdata  memory responses
//   busy              FSM not idle
import l1_arb_pkg::*;

module l1_ro_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 30,
    parameter int RLEN_W  = L1_ARB_RLEN_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_request,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*RLEN_W-1:0] req_rlen,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [NUM_REQ-1:0]        req_rvalid,
    output logic [31:0]               req_rdata,
    output logic                      mem_request,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [RLEN_W-1:0]         mem_rlen,
    input  logic                      mem_ack,
    input  logic                      mem_rvalid,
    input  logic [31:0]               mem_rdata,
    output logic                      busy
);

    localparam int ID_W = (NUM_REQ > 2) ? 2 : 1;

    l1_arb_state_t     state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [RLEN_W-1:0] rlen_q, rlen_d;
    logic [RLEN_W-1:0] cnt_q, cnt_d;

    logic [NUM_REQ-1:0] arb_req, sel_gnt, id_mask;
    logic [ID_W-1:0]    sel_id, sel_ptr;
    logic               sel_any;
    logic               grab;

    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [RLEN_W-1:0] rlen_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign rlen_arr[i] = req_rlen[i*RLEN_W +: RLEN_W];
    end

`ifdef L1_RO_ARBITER_ROUND_ROBIN_EN
    logic [ID_W-1:0] ptr_q, ptr_d;
    assign sel_ptr = ptr_q;
`else
    assign sel_ptr = '0;
`endif

    always_comb begin
        id_mask = '0;
        id_mask[id_q] = 1'b1;
        // On the last beat the current owner is excluded so another waiting
        // requester is taken back-to-back; an idle arbiter sees everyone.
        arb_req = (state_q == DATA) ? (req_request & ~id_mask) : req_request;
    end

    l1_arb_select #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_select (
        .req (arb_req),
        .ptr (sel_ptr),
        .gnt (sel_gnt),
        .id  (sel_id),
        .any (sel_any)
    );

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        addr_d     = addr_q;
        rlen_d     = rlen_q;
        cnt_d      = cnt_q;
        req_ack    = '0;
        req_rvalid = '0;
        grab       = 1'b0;
`ifdef L1_RO_ARBITER_ROUND_ROBIN_EN
        ptr_d      = ptr_q;
`endif

        case (state_q)
            IDLE: begin
                if (sel_any) grab = 1'b1;
            end
            REQ: begin
                if (mem_ack) begin
                    req_ack[id_q] = 1'b1;
                    cnt_d         = rlen_q;
                    state_d       = DATA;
                end
            end
            DATA: begin
                if (mem_rvalid) begin
                    req_rvalid[id_q] = 1'b1;
                    if (cnt_q == '0) begin
                        if (sel_any) grab = 1'b1;
                        else         state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (grab) begin
            state_d = REQ;
            id_d    = sel_id;
`ifdef L1_RO_ARBITER_ROUND_ROBIN_EN
            ptr_d   = sel_id;
`endif
            for (int i = 0; i < NUM_REQ; i++) begin
                if (sel_gnt[i]) begin
                    addr_d = addr_arr[i];
                    rlen_d = rlen_arr[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            rlen_q  <= '0;
            cnt_q   <= '0;
`ifdef L1_RO_ARBITER_ROUND_ROBIN_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            rlen_q  <= rlen_d;
            cnt_q   <= cnt_d;
`ifdef L1_RO_ARBITER_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign mem_request = (state_q == REQ);
    assign mem_addr    = addr_q;
    assign mem_rlen    = rlen_q;
    assign busy        = (state_q != IDLE);
    assign req_rdata   = mem_rdata;

    // Protocol checks on both sides of the arbiter.
    a_ack_in_req: assert property (@(posedge clk) disable iff (rst)
        mem_ack |-> (state_q == REQ))
        else $error("mem_ack outside REQ");

    a_rvalid_in_data: assert property (@(posedge clk) disable iff (rst)
        mem_rvalid |-> (state_q == DATA))
        else $error("mem_rvalid outside DATA");

    a_req_held: assert property (@(posedge clk) disable iff (rst)
        (state_q == REQ) |-> req_request[id_q])
        else $error("granted request dropped before ack");

endmodule

// File: tb/tb_l1_ro_arbiter.sv
// tb_l1_ro_arbiter: directed scoreboard bench for l1_ro_arbiter (NUM_REQ=2).
// Stimulus pushes expected memory requests, acks and beats into queues; an
// independent negedge monitor pops and compares whenever the DUT shows them.
module tb_l1_ro_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 30;
    localparam int RLEN_W  = 5;
`ifdef L1_RO_ARBITER_ROUND_ROBIN_EN
    localparam int FIRST = 1;   // pointer resets to 0, so req1 leads
`else
    localparam int FIRST = 0;   // lowest index leads
`endif

    logic                      clk, rst;
    logic [NUM_REQ-1:0]        req_request;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*RLEN_W-1:0] req_rlen;
    logic [NUM_REQ-1:0]        req_ack, req_rvalid;
    logic [31:0]               req_rdata;
    logic                      mem_request;
    logic [ADDR_W-1:0]         mem_addr;
    logic [RLEN_W-1:0]         mem_rlen;
    logic                      mem_ack, mem_rvalid;
    logic [31:0]               mem_rdata;
    logic                      busy;

    l1_ro_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .RLEN_W(RLEN_W)) dut (
        .clk(clk), .rst(rst),
        .req_request(req_request), .req_addr(req_addr), .req_rlen(req_rlen),
        .req_ack(req_ack), .req_rvalid(req_rvalid), .req_rdata(req_rdata),
        .mem_request(mem_request), .mem_addr(mem_addr), .mem_rlen(mem_rlen),
        .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [ADDR_W-1:0] addr; logic [RLEN_W-1:0] rlen; } mreq_t;
    typedef struct packed { logic [NUM_REQ-1:0] vld; logic [31:0] data; } beat_t;

    mreq_t              q_mreq [$];
    logic [NUM_REQ-1:0] q_ack  [$];
    beat_t              q_beat [$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic  mreq_prev = 1'b0;
    mreq_t m_exp;
    beat_t b_exp;
    logic [NUM_REQ-1:0] a_exp;

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_request && !mreq_prev) begin
                if (q_mreq.size() == 0) chk("unexpected mem_request", 64'(mem_request), 64'd0);
                else begin
                    m_exp = q_mreq.pop_front();
                    chk("mem_addr", 64'(mem_addr), 64'(m_exp.addr));
                    chk("mem_rlen", 64'(mem_rlen), 64'(m_exp.rlen));
                end
            end
            if (req_ack != '0) begin
                if (q_ack.size() == 0) chk("unexpected req_ack", 64'(req_ack), 64'd0);
                else begin
                    a_exp = q_ack.pop_front();
                    chk("req_ack", 64'(req_ack), 64'(a_exp));
                end
            end
            if (req_rvalid != '0) begin
                if (q_beat.size() == 0) chk("unexpected req_rvalid", 64'(req_rvalid), 64'd0);
                else begin
                    b_exp = q_beat.pop_front();
                    chk("req_rvalid", 64'(req_rvalid), 64'(b_exp.vld));
                    chk("req_rdata", 64'(req_rdata), 64'(b_exp.data));
                end
            end
        end
        mreq_prev <= mem_request;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NUM_REQ-1:0] onehot(input int id);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [RLEN_W-1:0] l);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_rlen[i*RLEN_W +: RLEN_W] = l;
        req_request[i] = 1'b1;
    endtask

    task automatic expect_req(input int id, input logic [ADDR_W-1:0] a, input logic [RLEN_W-1:0] l);
        mreq_t m;
        m.addr = a;
        m.rlen = l;
        q_mreq.push_back(m);
        q_ack.push_back(onehot(id));
    endtask

    task automatic expect_beat(input int id, input logic [31:0] d);
        beat_t b;
        b.vld  = onehot(id);
        b.data = d;
        q_beat.push_back(b);
    endtask

    task automatic wait_mreq(output bit ok);
        int k;
        k = 0;
        while (!mem_request && k < 20) begin
            step();
            k++;
        end
        ok = mem_request;
        if (!ok) chk("mem_request timeout", 64'(mem_request), 64'd1);
    endtask

    // Act as memory for one burst: optional ack stall, then rlen+1 beats.
    // drop clears those request bits right after the ack cycle.
    task automatic serve(input int id, input logic [ADDR_W-1:0] a, input logic [RLEN_W-1:0] l,
                         input int delay, input logic [31:0] base, input logic [NUM_REQ-1:0] drop);
        bit ok;
        expect_req(id, a, l);
        for (int b = 0; b <= int'(l); b++) expect_beat(id, base + 32'(b));
        wait_mreq(ok);
        if (!ok) return;
        for (int d = 0; d < delay; d++) begin
            chk("stall mem_request", 64'(mem_request), 64'd1);
            chk("stall mem_addr", 64'(mem_addr), 64'(a));
            chk("stall mem_rlen", 64'(mem_rlen), 64'(l));
            step();
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        req_request = req_request & ~drop;
        for (int b = 0; b <= int'(l); b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = base + 32'(b);
            step();
        end
        mem_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        chk("leftover mem requests", 64'(q_mreq.size()), 64'd0);
        chk("leftover acks", 64'(q_ack.size()), 64'd0);
        chk("leftover beats", 64'(q_beat.size()), 64'd0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int second;
        bit ok;
        rst = 1'b1;
        req_request = '0;
        req_addr = '0;
        req_rlen = '0;
        mem_ack = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 32'hA5A5_5A5A;
        step();
        step();
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset mem_request", 64'(mem_request), 64'd0);
        chk("reset req_ack", 64'(req_ack), 64'd0);
        chk("reset req_rvalid", 64'(req_rvalid), 64'd0);
        chk("reset mem_addr", 64'(mem_addr), 64'd0);
        chk("reset mem_rlen", 64'(mem_rlen), 64'd0);
        chk("reset rdata passthrough", 64'(req_rdata), 64'hA5A5_5A5A);
        rst = 1'b0;
        step();

        // single request, 8 beats
        set_req(0, 30'h100, 5'd7);
        step();
        chk("request latency", 64'(mem_request), 64'd1);
        serve(0, 30'h100, 5'd7, 0, 32'h1000_0000, 2'b01);
        chk("busy after single burst", 64'(busy), 64'd0);

        // simultaneous requests, back-to-back hand-over
        do_reset();
        second = 1 - FIRST;
        set_req(0, 30'h40, 5'd3);
        set_req(1, 30'h80, 5'd3);
        serve(FIRST, (FIRST == 0) ? 30'h40 : 30'h80, 5'd3, 0, 32'h2000, onehot(FIRST));
        chk("back-to-back busy", 64'(busy), 64'd1);
        chk("back-to-back mem_request", 64'(mem_request), 64'd1);
        chk("back-to-back mem_addr", 64'(mem_addr), (second == 0) ? 64'h40 : 64'h80);
        serve(second, (second == 0) ? 30'h40 : 30'h80, 5'd3, 1, 32'h3000, onehot(second));
        chk("busy after pair", 64'(busy), 64'd0);

        // continuous re-requests with rlen 0: grants alternate
        do_reset();
        set_req(0, 30'h300, 5'd0);
        set_req(1, 30'h340, 5'd0);
        for (int g = 0; g < 4; g++) begin
            int id;
            id = (FIRST + g) % 2;
            serve(id, (id == 0) ? 30'h300 : 30'h340, 5'd0, 0, 32'h4000 + 32'(g * 16),
                  (g == 3) ? 2'b11 : 2'b00);
        end
        chk("busy after alternation", 64'(busy), 64'd0);

        // stalled ack, 5 cycles
        do_reset();
        set_req(1, 30'h180, 5'd2);
        serve(1, 30'h180, 5'd2, 5, 32'h5000, 2'b10);
        chk("busy after stall", 64'(busy), 64'd0);

        // maximum burst length, 32 beats
        set_req(1, 30'h3FFF_FFC0, 5'd31);
        serve(1, 30'h3FFF_FFC0, 5'd31, 0, 32'hC000_0000, 2'b10);
        chk("busy after 32 beats", 64'(busy), 64'd0);

        // reset during the third of eight beats
        do_reset();
        set_req(0, 30'h500, 5'd7);
        expect_req(0, 30'h500, 5'd7);
        expect_beat(0, 32'h6000);
        expect_beat(0, 32'h6001);
        wait_mreq(ok);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        req_request[0] = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h6000 + 32'(b);
            step();
        end
        mem_rdata = 32'h6002;
        rst = 1'b1;
        #1;
        chk("mid-burst reset busy", 64'(busy), 64'd0);
        chk("mid-burst reset mem_request", 64'(mem_request), 64'd0);
        chk("mid-burst reset req_rvalid", 64'(req_rvalid), 64'd0);
        step();
        mem_rvalid = 1'b0;
        step();
        rst = 1'b0;
        step();
        set_req(1, 30'h200, 5'd1);
        serve(1, 30'h200, 5'd1, 0, 32'h7000, 2'b10);
        chk("busy after recovery", 64'(busy), 64'd0);

        step();
        step();
        chk("final mem request queue", 64'(q_mreq.size()), 64'd0);
        chk("final ack queue", 64'(q_ack.size()), 64'd0);
        chk("final beat queue", 64'(q_beat.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/l1_ro_arbiter.md
Name: l1_ro_arbiter

Overview:
- Shares one read-only burst memory port (request/ack/rvalid/rdata) between NUM_REQ line-fill requesters, e.g. instruction cache and data cache read misses.
- Sits between the caches' master read-only memory interfaces and the L1/memory side.
- Latches the winning request, forwards it, routes the ack back to the winner, and steers the (rlen+1)-beat response to the winner only.
- One burst outstanding at a time.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 30, word-address width (byte address bits [31:2]).
- RLEN_W, 5, burst length field width; burst beats = rlen+1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_request  in  NUM_REQ  per-requester line-fill request, held until its ack.
- req_addr  in  NUM_REQ x ADDR_W  per-requester word address.
- req_rlen  in  NUM_REQ x RLEN_W  per-requester burst length minus 1.
- req_ack  out  NUM_REQ  one-hot, 1-cycle acceptance to the winner.
- req_rvalid  out  NUM_REQ  one-hot data beat valid to the granted requester.
- req_rdata  out  32  beat data, broadcast to all requesters.
- mem_request  out  1  request to memory.
- mem_addr  out  ADDR_W  latched address.
- mem_rlen  out  RLEN_W  latched burst length.
- mem_ack  in  1  memory accepted the request.
- mem_rvalid  in  1  memory data beat.
- mem_rdata  in  32  memory data.
- busy  out  1  state != IDLE.

Behaviour:
- States:
  - IDLE: no grant held.
  - REQ: mem_request=1, waiting for mem_ack.
  - DATA: counting beats.
- Reset (async, any state): state=IDLE, grant id=0, beat counter=0, mem_addr/mem_rlen=0, RR pointer=0. All outputs 0 except req_rdata, which passes mem_rdata through.
- IDLE, with any req_request set:
  - Select winner per the priority rule.
  - Register id, addr, rlen.
  - Go to REQ. mem_request rises the cycle after req_request is first seen, so latency is 1 cycle.
- REQ:
  - mem_request, mem_addr, mem_rlen held stable until mem_ack.
  - On mem_ack: req_ack[id]=1 combinationally in the same cycle; load counter=rlen; go to DATA.
- DATA, on each mem_rvalid:
  - req_rvalid[id]=1 and the counter decrements.
  - The beat with counter==0 is the last beat.
- Last beat, boundary cases:
  - If any req_request is pending (excluding id), arbitrate in the same cycle and go directly to REQ (back-to-back, no IDLE bubble). Otherwise go to IDLE.
  - A requester that was just served and re-requests competes normally.
- Width: counter is RLEN_W bits. rlen=0 gives exactly one beat; rlen=2^RLEN_W-1 gives 32 beats with no wrap error.
- Default priority is fixed: lowest index wins.
- mem_ack outside REQ and mem_rvalid outside DATA are ignored; both are flagged by assertions.
- req_request[id] dropping while in REQ violates the protocol and is flagged by an assertion.
- Reset mid-burst abandons the burst. The memory side shares the same rst, so no stale beats arrive.

Optional Feature:
- Macro: L1_RO_ARBITER_ROUND_ROBIN_EN.
- Defined:
  - Round-robin arbitration.
  - Pointer register holds the last granted id; priority search starts at pointer+1 modulo NUM_REQ.
  - Pointer updates on every grant.
  - After reset the pointer is 0, so req1 has highest priority.
- Undefined: fixed priority, no pointer register.

Decomposition:
- Shared package (cache_functions_pkg or a new l1_arb_pkg):
  - l1_arb_state_t enum {IDLE, REQ, DATA}.
  - L1_ARB_RLEN_W = 5.
- Sub-module l1_arb_select: combinational priority/round-robin chooser.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant and encoded id; reuses priority_encoder.

Test Plan:
- Single request: req0 with addr 0x100 and rlen 7 -> mem_request the next cycle with mem_addr 0x100 and mem_rlen 7. mem_ack gives req_ack=01. Eight mem_rvalid beats give req_rvalid=01 each. busy drops the cycle after the 8th beat.
- Simultaneous requests, fixed priority: req0 (0x40, rlen 3) and req1 (0x80, rlen 3) together -> req0 served first. At req0's 4th beat, state goes straight to REQ with mem_addr 0x80. req1 receives its ack and 4 beats.
- Round-robin (macro defined): both requesters re-request continuously with rlen 0 -> grants alternate 1,0,1,0, starting with req1 after reset.
- Stalled ack: mem_ack delayed 5 cycles -> mem_request, mem_addr and mem_rlen are stable for all 5 cycles. req_ack pulses exactly once.
- Reset mid-burst: rst asserted during beat 3 of 8 -> busy, mem_request and req_rvalid go to 0 immediately. After release, a new req1 request (0x200, rlen 1) completes normally.
- Spurious data: mem_rvalid pulsed while IDLE -> no req_rvalid output and the assertion fires.
